mainmem_arbiter: RTL and testbench
==================================

Name: mainmem_arbiter

Overview:
- Shares one main memory port (split read/write address buses, 1-cycle synchronous read, single write enable) between NUM_PORTS requesters, e.g. several core0 instances or a core plus a loader.
- Read and write channels are arbitrated independently, each by its own round-robin pointer.
- Each cycle the block issues at most one read and at most one write to memory.
- It routes the returning read word to the winning requester with a one-cycle-delayed valid strobe.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
- MAIN_ADDR_WIDTH, 2, main memory address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_PORTS  per-port read request; held until granted.
- req_read_addr  in  NUM_PORTS*MAIN_ADDR_WIDTH  packed read addresses, port i at slice i.
- req_write  in  NUM_PORTS  per-port write request; held until granted.
- req_write_addr  in  NUM_PORTS*MAIN_ADDR_WIDTH  packed write addresses.
- req_write_value  in  NUM_PORTS*WORD_WIDTH  packed write data.
- read_grant  out  NUM_PORTS  one-hot or zero; read accepted this cycle.
- write_grant  out  NUM_PORTS  one-hot or zero; write accepted this cycle.
- read_valid  out  NUM_PORTS  one-hot or zero; read_value is valid for this port.
- read_value  out  WORD_WIDTH  broadcast read data (mainmem_read_value passthrough).
- mainmem_read_addr  out  MAIN_ADDR_WIDTH  to memory.
- mainmem_write_addr  out  MAIN_ADDR_WIDTH  to memory.
- mainmem_read_value  in  WORD_WIDTH  from memory, valid one cycle after address.
- mainmem_write_value  out  WORD_WIDTH  to memory.
- mainmem_we  out  1  memory write enable.

Behaviour:
- Grants are combinational from requests and the round-robin pointers, so a request is accepted in the same cycle it is presented.
- Read channel: winner is the first set req_read bit at or after read_ptr, scanning upward modulo NUM_PORTS. read_grant is one-hot on the winner. mainmem_read_addr equals the winner's address, or 0 if there is no winner.
- Write channel: same scheme using write_ptr. mainmem_we = |write_grant. Write address and data are muxed from the winner, and are 0 when there is no winner.
- Pointer update: on a cycle with a grant to port k, the pointer becomes (k+1) mod NUM_PORTS. With no grant, the pointer holds. A port requesting continuously waits at most NUM_PORTS-1 cycles.
- Read return: read_valid register = read_grant registered (latency 1). read_value = mainmem_read_value unregistered.
- Back-to-back reads from any ports are fully pipelined, one per cycle.
- A read and a write to the same address in the same cycle are passed through unchanged; no forwarding. The returned value is the memory's old contents.
- Read and write grants in the same cycle may go to the same port or to different ports.
- The requester owns request hold: it deasserts req_* in the cycle after seeing its grant. A request left high is treated as a new request.
- Reset (synchronous): read_ptr = 0, write_ptr = 0, read_valid = 0. While reset is high, read_grant = 0, write_grant = 0 and mainmem_we = 0 regardless of requests.
- Reset mid-operation: an in-flight read (granted in the reset cycle or the cycle before) produces no read_valid after reset.
- Writes are never issued during reset.

Decomposition:
- Package core0_mem_pkg: WORD_WIDTH and MAIN_ADDR_WIDTH defaults, and a function mapping port index to packed-slice offset.
- Sub-module rr_arbiter: NUM_PORTS requests in, one-hot grant out, owns its pointer with synchronous reset. Instantiated twice, once for the read channel and once for the write channel.
- Address, data and we muxing and the read_valid register live in the top module.

Test Plan:
- Reset: hold reset with all requests high -> all grants 0, mainmem_we 0, read_valid 0. First cycle after reset grants port 0 on both channels.
- Round-robin reads, NUM_PORTS=2: both ports hold req_read for 4 cycles, addrs 1 and 2 -> read_grant 01,10,01,10. read_valid follows one cycle later, with read_value = mem[1], mem[2], mem[1], mem[2].
- Write then read: port 1 writes 0xDEADBEEF to addr 3 at cycle t; port 0 reads addr 3 at t+1 -> read_valid=01 at t+2 with read_value 0xDEADBEEF.
- Same-cycle hazard: mem[2]=5; port 0 writes 9 to addr 2 while port 1 reads addr 2 -> port 1 receives 5, and a later read returns 9.
- Fairness: port 0 requests writes every cycle; port 1 requests once at cycle 3 -> port 1 is granted within 1 cycle.
- Reset mid-read: grant a read, assert reset the next cycle -> read_valid stays 0 and pointers return to 0.

Source files
------------

// File: rtl/core0_mem_pkg.sv
// Shared defaults and packed-bus helpers for the main memory arbiter.
package core0_mem_pkg;

  localparam int WORD_MAG_DEF        = 5;
  localparam int WORD_WIDTH_DEF      = 1 << WORD_MAG_DEF;
  localparam int MAIN_ADDR_WIDTH_DEF = 2;

  // Lowest bit of port idx's slice within a packed per-port bus.
  function automatic int port_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first request at or after the pointer.
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] grant_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;
  int               nxt;

  // Grants are suppressed during reset so nothing reaches memory.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    nxt     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_PORTS;
      if (!found && !reset && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        nxt          = (idx + 1) % NUM_PORTS;
        ptr_d        = PTR_W'(nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mainmem_arbiter.sv
// Shares one main memory port among NUM_PORTS requesters with independent
// round-robin read and write channels and a one-cycle read-valid return.
module mainmem_arbiter
  import core0_mem_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int WORD_MAG        = WORD_MAG_DEF,
  parameter int MAIN_ADDR_WIDTH = MAIN_ADDR_WIDTH_DEF,
  localparam int WORD_WIDTH     = 1 << WORD_MAG
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS*MAIN_ADDR_WIDTH-1:0] req_read_addr,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS*MAIN_ADDR_WIDTH-1:0] req_write_addr,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0]      req_write_value,
  output logic [NUM_PORTS-1:0]                 read_grant,
  output logic [NUM_PORTS-1:0]                 write_grant,
  output logic [NUM_PORTS-1:0]                 read_valid,
  output logic [WORD_WIDTH-1:0]                read_value,
  output logic [MAIN_ADDR_WIDTH-1:0]           mainmem_read_addr,
  output logic [MAIN_ADDR_WIDTH-1:0]           mainmem_write_addr,
  input  logic [WORD_WIDTH-1:0]                mainmem_read_value,
  output logic [WORD_WIDTH-1:0]                mainmem_write_value,
  output logic                                 mainmem_we
);

  logic [NUM_PORTS-1:0] read_valid_q, read_valid_d;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req_read),
    .grant_o(read_grant)
  );

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req_write),
    .grant_o(write_grant)
  );

  always_comb begin
    mainmem_read_addr   = '0;
    mainmem_write_addr  = '0;
    mainmem_write_value = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (read_grant[i])
        mainmem_read_addr = req_read_addr[port_lo(i, MAIN_ADDR_WIDTH) +: MAIN_ADDR_WIDTH];
      if (write_grant[i]) begin
        mainmem_write_addr  = req_write_addr[port_lo(i, MAIN_ADDR_WIDTH) +: MAIN_ADDR_WIDTH];
        mainmem_write_value = req_write_value[port_lo(i, WORD_WIDTH) +: WORD_WIDTH];
      end
    end
  end

  assign mainmem_we = |write_grant;
  assign read_value = mainmem_read_value;

  assign read_valid_d = reset ? '0 : read_grant;

  always_ff @(posedge clk) begin
    if (reset) read_valid_q <= '0;
    else       read_valid_q <= read_valid_d;
  end

  // A read granted just before reset must not surface while reset is held.
  assign read_valid = read_valid_q & {NUM_PORTS{~reset}};

endmodule

// File: tb/tb_mainmem_arbiter.sv
// Directed bench for mainmem_arbiter with a small synchronous memory attached.
module tb_mainmem_arbiter;

  localparam int N  = 2;
  localparam int AW = 2;
  localparam int WW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read, req_write;
  logic [N*AW-1:0] req_read_addr, req_write_addr;
  logic [N*WW-1:0] req_write_value;
  logic [N-1:0]    read_grant, write_grant, read_valid;
  logic [WW-1:0]   read_value, mainmem_read_value, mainmem_write_value;
  logic [AW-1:0]   mainmem_read_addr, mainmem_write_addr;
  logic            mainmem_we;

  logic [WW-1:0]   mem [4];
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  mainmem_arbiter #(.NUM_PORTS(N), .WORD_MAG(5), .MAIN_ADDR_WIDTH(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_read           (req_read),
    .req_read_addr      (req_read_addr),
    .req_write          (req_write),
    .req_write_addr     (req_write_addr),
    .req_write_value    (req_write_value),
    .read_grant         (read_grant),
    .write_grant        (write_grant),
    .read_valid         (read_valid),
    .read_value         (read_value),
    .mainmem_read_addr  (mainmem_read_addr),
    .mainmem_write_addr (mainmem_write_addr),
    .mainmem_read_value (mainmem_read_value),
    .mainmem_write_value(mainmem_write_value),
    .mainmem_we         (mainmem_we)
  );

  // Memory contents restore to known values whenever reset is high.
  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= 32'h0000_0011;
      mem[1] <= 32'hAAAA_0001;
      mem[2] <= 32'hBBBB_0002;
      mem[3] <= 32'h0000_0033;
    end else if (mainmem_we) begin
      mem[mainmem_write_addr] <= mainmem_write_value;
    end
    mainmem_read_value <= mem[mainmem_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_read  = '0;
    req_write = '0;
  endtask

  initial begin
    reset           = 1'b1;
    req_read        = 2'b11;
    req_write       = 2'b11;
    req_read_addr   = '0;
    req_write_addr  = '0;
    req_write_value = {32'h0000_0066, 32'h0000_0055};

    // Reset with everything requesting
    tick(); tick();
    chk("rst_rgrant", 32'(read_grant), 32'h0);
    chk("rst_wgrant", 32'(write_grant), 32'h0);
    chk("rst_we", 32'(mainmem_we), 32'h0);
    chk("rst_rvalid", 32'(read_valid), 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_rgrant", 32'(read_grant), 32'h1);
    chk("post_rst_wgrant", 32'(write_grant), 32'h1);
    chk("post_rst_wdata", mainmem_write_value, 32'h0000_0055);
    tick();
    idle();
    chk("post_rst_rvalid", 32'(read_valid), 32'h1);
    chk("post_rst_rvalue", read_value, 32'h0000_0011);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Round-robin reads: port0 addr 1, port1 addr 2
    req_read      = 2'b11;
    req_read_addr = {2'd2, 2'd1};
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_read = '0;
      #1;
      if (k < 4) begin
        chk("rr_grant", 32'(read_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
        chk("rr_addr", 32'(mainmem_read_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      if (k > 0) begin
        chk("rr_valid", 32'(read_valid), (k % 2 == 1) ? 32'h1 : 32'h2);
        chk("rr_value", read_value, (k % 2 == 1) ? 32'hAAAA_0001 : 32'hBBBB_0002);
      end
      tick();
    end
    chk("rr_idle_valid", 32'(read_valid), 32'h0);

    // Port1 writes addr 3, port0 reads it next cycle
    req_write       = 2'b10;
    req_write_addr  = {2'd3, 2'd0};
    req_write_value = {32'hDEAD_BEEF, 32'h0};
    #1;
    chk("wr_grant", 32'(write_grant), 32'h2);
    chk("wr_we", 32'(mainmem_we), 32'h1);
    chk("wr_addr", 32'(mainmem_write_addr), 32'd3);
    chk("wr_data", mainmem_write_value, 32'hDEAD_BEEF);
    tick();
    req_write     = '0;
    req_read      = 2'b01;
    req_read_addr = {2'd0, 2'd3};
    #1;
    chk("wr_idle_we", 32'(mainmem_we), 32'h0);
    chk("wr_idle_waddr", 32'(mainmem_write_addr), 32'h0);
    chk("wrr_grant", 32'(read_grant), 32'h1);
    tick();
    idle();
    chk("wrr_valid", 32'(read_valid), 32'h1);
    chk("wrr_value", read_value, 32'hDEAD_BEEF);
    tick();

    // Same-cycle read/write to one address returns old contents
    req_write       = 2'b01;
    req_write_addr  = {2'd0, 2'd2};
    req_write_value = {32'h0, 32'd5};
    tick();
    req_write_value = {32'h0, 32'd9};
    req_read        = 2'b10;
    req_read_addr   = {2'd2, 2'd0};
    #1;
    chk("haz_wgrant", 32'(write_grant), 32'h1);
    chk("haz_rgrant", 32'(read_grant), 32'h2);
    tick();
    req_write     = '0;
    req_read      = 2'b01;
    req_read_addr = {2'd0, 2'd2};
    #1;
    chk("haz_old_valid", 32'(read_valid), 32'h2);
    chk("haz_old_value", read_value, 32'd5);
    tick();
    idle();
    chk("haz_new_valid", 32'(read_valid), 32'h1);
    chk("haz_new_value", read_value, 32'd9);
    tick();

    // Fairness: port0 writes continuously, port1 joins at cycle 3
    req_write_addr  = {2'd1, 2'd0};
    req_write_value = {32'h0000_0088, 32'h0000_0077};
    for (int c = 0; c < 5; c++) begin
      req_write = (c == 3) ? 2'b11 : 2'b01;
      #1;
      chk("fair_grant", 32'(write_grant), (c == 3) ? 32'h2 : 32'h1);
      tick();
    end
    idle();

    // Reset one cycle after a read grant
    req_read      = 2'b01;
    req_read_addr = {2'd0, 2'd1};
    #1;
    chk("mid_grant", 32'(read_grant), 32'h1);
    tick();
    req_read = '0;
    reset    = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(read_valid), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_post_valid", 32'(read_valid), 32'h0);
    req_read       = 2'b11;
    req_write      = 2'b11;
    req_write_addr = {2'd3, 2'd3};
    #1;
    chk("mid_rptr0", 32'(read_grant), 32'h1);
    chk("mid_wptr0", 32'(write_grant), 32'h1);
    tick();
    idle();
    chk("mid_final_valid", 32'(read_valid), 32'h1);
    chk("mid_final_value", read_value, 32'hAAAA_0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
